serial_magnitude_comparator: RTL
================================

# serial_magnitude_comparator

Parametrised, framed serial comparator. Two unsigned operands of DIGIT_W × NUM_DIGITS bits arrive one DIGIT_W-bit digit per accepted beat. Digit order is selectable per frame: most-significant-first or least-significant-first. A single-cycle-valid, registered less/equal/greater verdict is produced at the end of each frame. It is the multi-bit, framed, error-checking successor of the team's 1-bit serial comparators and sits between serialising datapaths and control logic that needs ordered compares.

## Interface
- DIGIT_W, 1: bits per digit (≥1)
- NUM_DIGITS, 8: digits per frame (≥1); operand width = DIGIT_W*NUM_DIGITS
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- valid  in  1  beat qualifier; low = stall, state held
- first  in  1  beat is first digit of a frame
- last  in  1  beat is last digit of a frame
- lsb_first  in  1  order select: 0 = MS digit first, 1 = LS digit first; sampled only on the first beat
- a, b  in  DIGIT_W  current digits
- result_valid  out  1  one-cycle pulse: verdict outputs just updated
- a_less_b, a_eq_b, a_greater_b  out  1 each  registered verdict, one-hot, held until next result
- frame_err  out  1  one-cycle pulse on framing violation

## Operation
- FSM states: IDLE, ACTIVE. Digit counter cnt is 0..NUM_DIGITS-1. Running state is lt, eq, plus the latched order bit.
- Digit compare is unsigned. d_lt = a<b, d_eq = a==b.
- MSB-first update: if eq then (lt,eq) ← (d_lt,d_eq), else hold.
- LSB-first update: if !d_eq then (lt,eq) ← (d_lt,0), else hold.
- First beat: running state is seeded as if prior was (lt=0, eq=1). The first beat also latches lsb_first and sets cnt=1.
- IDLE + valid&first: the digit is consumed. Go to ACTIVE, unless last is also set.
- ACTIVE + valid&!first&!last: the digit is consumed and cnt++.
- valid&last with cnt==NUM_DIGITS-1 (including first&last with NUM_DIGITS==1):
  - the final digit is folded in and the verdict is registered;
  - result_valid pulses; the FSM goes to IDLE.
- Error cases (each pulses frame_err; none produces a result):
  - IDLE + valid&!first: beat dropped.
  - last at wrong count: FSM goes to IDLE.
  - ACTIVE + first: frame abandoned, and the beat starts a new frame.
  - ACTIVE + !last when cnt==NUM_DIGITS-1: FSM goes to IDLE.
- a_greater_b = !a_less_b & !a_eq_b. Exactly one verdict output is high at all times.

## Timing
- Reset values: FSM IDLE, cnt 0, result_valid 0, a_eq_b 1, a_less_b 0, a_greater_b 0, frame_err 0.
- Latency: the verdict and result_valid appear on the cycle after the last beat is accepted.
- Throughput: a new frame's first beat may arrive on the cycle immediately after the previous last beat. Back-to-back frames run at full rate.
- Stalls (valid=0) can be any length. first, last, lsb_first, a and b are ignored when valid=0.
- rst mid-frame: the partial frame is discarded. All outputs take reset values on the next edge, with no result_valid and no frame_err.
- Verdict outputs never change except on a result_valid cycle or on reset.

## Configuration
- SERIAL_CMP_SIGNED_EN defined:
  - adds input port is_signed (1 bit), sampled on the first beat;
  - when set, operands are two's complement, implemented by inverting the top bit of a and b in the sign digit before compare;
  - the sign digit is the first beat when MSB-first and the last beat when LSB-first.
- Undefined: no is_signed port; compare is always unsigned.

## Structure
- Package serial_cmp_pkg:
  - state_t enum {IDLE, ACTIVE};
  - verdict_t enum {LT, EQ, GT};
  - helper function for counter width, $clog2(NUM_DIGITS) with a minimum of 1.
- Sub-module serial_cmp_digit: combinational DIGIT_W-bit compare producing d_lt and d_eq. It includes the optional sign-bit inversion, controlled by a port.
- Top module holds the FSM, counter, running state and output registers.

## Test plan
- DIGIT_W=1, NUM_DIGITS=8, MSB-first, a=0x5A, b=0x5B, no stalls → result_valid one cycle after the 8th beat; a_less_b=1.
- DIGIT_W=4, NUM_DIGITS=2, LSB-first, a=0x3F, b=0x2F, random valid gaps → a_greater_b=1. The verdict holds until the next frame.
- Back-to-back frames with a=b=0xC3, then a=0x00 b=0xFF (MSB-first) → consecutive result_valid pulses showing a_eq_b=1, then a_less_b=1.
- Framing errors, each → frame_err=1 and no result_valid:
  - last after 5 of 8 beats;
  - first mid-frame (the new frame then completes correctly);
  - beat without first in IDLE.
- rst asserted after 3 beats → all outputs at reset values. A following clean frame with a=0x80, b=0x7F → a_greater_b=1.
- SERIAL_CMP_SIGNED_EN with is_signed=1, a=0x80 (−128), b=0x7F, both orders → a_less_b=1. With is_signed=0 → a_greater_b=1.

Source files
------------

// File: rtl/serial_cmp_pkg.sv
// rtl/serial_cmp_pkg.sv - shared types and helpers for the serial magnitude comparator
package serial_cmp_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    LT = 2'd0,
    EQ = 2'd1,
    GT = 2'd2
  } verdict_t;

  // Digit counter width; never narrower than one bit so NUM_DIGITS=1 still has a counter.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_cmp_digit.sv
// rtl/serial_cmp_digit.sv - combinational unsigned digit compare with optional sign-bit flip
module serial_cmp_digit #(
  parameter int DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] a_i,
  input  logic [DIGIT_W-1:0] b_i,
  input  logic               invert_msb_i,
  output logic               d_lt_o,
  output logic               d_eq_o
);

  logic [DIGIT_W-1:0] flip;
  logic [DIGIT_W-1:0] a_x;
  logic [DIGIT_W-1:0] b_x;

  // Flipping the top bit of both digits maps two's complement onto unsigned order.
  always_comb begin
    flip              = '0;
    flip[DIGIT_W-1]   = invert_msb_i;
    a_x               = a_i ^ flip;
    b_x               = b_i ^ flip;
    d_lt_o            = a_x < b_x;
    d_eq_o            = a_x == b_x;
  end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - framed serial comparator, MS- or LS-digit-first per frame
// Optional signed compare enabled by defining SERIAL_CMP_SIGNED_EN (adds is_signed input).
module serial_magnitude_comparator
  import serial_cmp_pkg::*;
#(
  parameter int DIGIT_W    = 1,
  parameter int NUM_DIGITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic               first,
  input  logic               last,
  input  logic               lsb_first,
`ifdef SERIAL_CMP_SIGNED_EN
  input  logic               is_signed,
`endif
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               result_valid,
  output logic               a_less_b,
  output logic               a_eq_b,
  output logic               a_greater_b,
  output logic               frame_err
);

  localparam int CNT_W = cnt_width(NUM_DIGITS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_DIGITS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             lsb_q, lsb_d;
  verdict_t         verdict_q, verdict_d;
  logic             rv_q, rv_d;
  logic             fe_q, fe_d;
`ifdef SERIAL_CMP_SIGNED_EN
  logic             sgn_q, sgn_d;
`endif

  logic             order;
  logic [CNT_W-1:0] idx;
  logic             at_end;
  logic             in_frame;
  logic             signed_now;
  logic             invert;
  logic             prior_lt, prior_eq;
  logic             fold_lt, fold_eq;
  logic             d_lt, d_eq;

  serial_cmp_digit #(
    .DIGIT_W(DIGIT_W)
  ) u_digit (
    .a_i         (a),
    .b_i         (b),
    .invert_msb_i(invert),
    .d_lt_o      (d_lt),
    .d_eq_o      (d_eq)
  );

  // A first beat reseeds the running state, so idx/order/sign come from the beat itself.
  always_comb begin
    order    = first ? lsb_first : lsb_q;
    idx      = first ? '0 : cnt_q;
    at_end   = (idx == LAST_IDX);
    in_frame = first | (state_q == ACTIVE);
`ifdef SERIAL_CMP_SIGNED_EN
    signed_now = first ? is_signed : sgn_q;
`else
    signed_now = 1'b0;
`endif
    invert   = signed_now & (order ? at_end : (idx == '0));
    prior_lt = first ? 1'b0 : lt_q;
    prior_eq = first ? 1'b1 : eq_q;
    fold_lt  = prior_lt;
    fold_eq  = prior_eq;
    if (!order) begin
      if (prior_eq) begin
        fold_lt = d_lt;
        fold_eq = d_eq;
      end
    end else if (!d_eq) begin
      fold_lt = d_lt;
      fold_eq = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lt_d      = lt_q;
    eq_d      = eq_q;
    lsb_d     = lsb_q;
    verdict_d = verdict_q;
    rv_d      = 1'b0;
    fe_d      = 1'b0;
`ifdef SERIAL_CMP_SIGNED_EN
    sgn_d     = sgn_q;
`endif
    if (valid) begin
      if (!in_frame) begin
        fe_d = 1'b1;
      end else begin
        fe_d = first & (state_q == ACTIVE);
        if (last != at_end) begin
          fe_d    = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (last) begin
          verdict_d = fold_lt ? LT : (fold_eq ? EQ : GT);
          rv_d      = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end else begin
          state_d = ACTIVE;
          cnt_d   = idx + CNT_W'(1);
          lt_d    = fold_lt;
          eq_d    = fold_eq;
          lsb_d   = order;
`ifdef SERIAL_CMP_SIGNED_EN
          sgn_d   = signed_now;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lt_q      <= 1'b0;
      eq_q      <= 1'b1;
      lsb_q     <= 1'b0;
      verdict_q <= EQ;
      rv_q      <= 1'b0;
      fe_q      <= 1'b0;
`ifdef SERIAL_CMP_SIGNED_EN
      sgn_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lt_q      <= lt_d;
      eq_q      <= eq_d;
      lsb_q     <= lsb_d;
      verdict_q <= verdict_d;
      rv_q      <= rv_d;
      fe_q      <= fe_d;
`ifdef SERIAL_CMP_SIGNED_EN
      sgn_q     <= sgn_d;
`endif
    end
  end

  assign result_valid = rv_q;
  assign frame_err    = fe_q;
  assign a_less_b     = (verdict_q == LT);
  assign a_eq_b       = (verdict_q == EQ);
  assign a_greater_b  = !a_less_b & !a_eq_b;

endmodule
